// File: rtl/input_debouncer.sv
// Synchronises the raw `in` line and debounces it with a four-state filter FSM, producing a
// registered level, one-cycle rise/fall strobes and a saturating count of rejected glitches.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in,
    input  logic                en,
    input  logic                glitch_clr,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        LOW   = 2'd0,
        CHK_H = 2'd1,
        HIGH  = 2'd2,
        CHK_L = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    STABLE_N   = CNT_W'(STABLE_CYCLES);
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = {{(GLITCH_W-1){1'b0}}, 1'b1};
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   cnt_done;

    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;
    logic                   glitch_ev;

    // Synchroniser keeps sampling even while the filter is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign cnt_done = (cnt_inc == STABLE_N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOW;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en) begin
            case (state_q)
                LOW: begin
                    if (s) begin
                        state_d = CHK_H;
                        cnt_d   = CNT_ONE;
                    end
                end
                CHK_H: begin
                    if (!s) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else if (cnt_done) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_d = CHK_L;
                        cnt_d   = CNT_ONE;
                    end
                end
                CHK_L: begin
                    if (s) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else if (cnt_done) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rise_d    = en && (state_q == CHK_H) &&  s && cnt_done;
        fall_d    = en && (state_q == CHK_L) && !s && cnt_done;
        glitch_ev = en && (((state_q == CHK_H) && !s) || ((state_q == CHK_L) && s));

        level_d = level_q;
        if (rise_d) begin
            level_d = 1'b1;
        end else if (fall_d) begin
            level_d = 1'b0;
        end

        // Clear takes priority over a glitch landing in the same cycle.
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_ev && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + GLITCH_ONE;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign glitch_cnt = glitch_q;
    assign state      = state_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer at default parameters.
module tb_input_debouncer;

    logic       clk;
    logic       rst;
    logic       in;
    logic       en;
    logic       glitch_clr;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] glitch_cnt;
    logic [1:0] state;

    int n_pass  = 0;
    int n_total = 0;

    logic saw_rise;
    logic saw_level;

    input_debouncer dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .en         (en),
        .glitch_clr (glitch_clr),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .glitch_cnt (glitch_cnt),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in         = 1'b0;
        en         = 1'b1;
        glitch_clr = 1'b0;
        saw_rise   = 1'b0;
        saw_level  = 1'b0;

        // Reset held for two edges, released at t=16
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_level", level, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_glitch", glitch_cnt, 0);
        check("rst_state", state, 0);

        // Clean rise at t=23: accepted on the 5th edge (t=65)
        #7;
        in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("rise_wait_level", level, 0);
            check("rise_wait_rise", rise, 0);
        end
        tick();
        check("rise_strobe", rise, 1);
        check("rise_level", level, 1);
        check("rise_state", state, 2);
        check("rise_no_fall", fall, 0);
        tick();
        check("rise_one_cycle", rise, 0);
        check("rise_level_hold", level, 1);
        check("rise_glitch", glitch_cnt, 0);

        // Clean fall from HIGH
        #2;
        in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("fall_wait_level", level, 1);
            check("fall_wait_fall", fall, 0);
        end
        tick();
        check("fall_strobe", fall, 1);
        check("fall_level", level, 0);
        check("fall_no_rise", rise, 0);
        check("fall_state", state, 0);
        tick();
        check("fall_one_cycle", fall, 0);

        // Two-period pulse is rejected
        in = 1'b1;
        tick();
        tick();
        in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("pulse_no_rise", rise, 0);
            check("pulse_no_level", level, 0);
        end
        check("pulse_glitch", glitch_cnt, 1);
        check("pulse_state", state, 0);

        // Chatter: 7 ns high / 12 ns low
        fork
            begin
                repeat (15) begin
                    in = 1'b1;
                    #7;
                    in = 1'b0;
                    #12;
                end
            end
            begin
                repeat (28) begin
                    @(negedge clk);
                    if (rise)  saw_rise  = 1'b1;
                    if (level) saw_level = 1'b1;
                end
            end
        join
        in = 1'b0;
        repeat (4) tick();
        check("chatter_rise", saw_rise, 0);
        check("chatter_level", saw_level, 0);
        check("chatter_glitch_nz", glitch_cnt > 8'd1, 1);
        check("chatter_state", state, 0);

        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        check("clr_glitch", glitch_cnt, 0);

        // One-cycle pulses: k pulses leave k-1 glitches counted
        repeat (100) begin
            in = 1'b1;
            tick();
            in = 1'b0;
            tick();
        end
        check("glitch_99", glitch_cnt, 99);
        repeat (200) begin
            in = 1'b1;
            tick();
            in = 1'b0;
            tick();
        end
        repeat (3) tick();
        check("glitch_sat", glitch_cnt, 255);
        check("glitch_sat_state", state, 0);

        // Clear coinciding with a glitch yields 0
        in = 1'b1;
        tick();
        in = 1'b0;
        tick();
        tick();
        check("clrwin_chk_h", state, 1);
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        check("clrwin_glitch", glitch_cnt, 0);
        check("clrwin_state", state, 0);
        in = 1'b1;
        tick();
        in = 1'b0;
        repeat (3) tick();
        check("after_clr_glitch", glitch_cnt, 1);

        // Async reset while in CHK_H
        in = 1'b1;
        repeat (3) tick();
        check("mid_chk_h", state, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_glitch", glitch_cnt, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("post_rst_wait", level, 0);
        end
        tick();
        check("post_rst_rise", rise, 1);
        check("post_rst_level", level, 1);

        // Async reset from HIGH drops level before the next edge
        #3;
        rst = 1'b1;
        in  = 1'b0;
        #1;
        check("async_rst_level", level, 0);
        check("async_rst_rise", rise, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (3) tick();

        // Enable freeze
        en = 1'b0;
        in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("freeze_level", level, 0);
            check("freeze_rise", rise, 0);
        end
        check("freeze_state", state, 0);
        en = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            check("resume_wait", level, 0);
        end
        tick();
        check("resume_rise", rise, 1);
        check("resume_level", level, 1);
        tick();
        check("resume_rise_one", rise, 0);

        // Frozen in HIGH: input activity neither moves the FSM nor counts glitches
        en = 1'b0;
        in = 1'b0;
        repeat (4) tick();
        check("freeze_hi_state", state, 2);
        check("freeze_hi_level", level, 1);
        check("freeze_hi_fall", fall, 0);
        in = 1'b1;
        repeat (4) tick();
        en = 1'b1;
        repeat (2) tick();
        check("unfreeze_state", state, 2);
        check("unfreeze_glitch", glitch_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Upstream conditioning stage for the edge-counting counter. Takes a raw asynchronous `in` line, synchronises it into the `clk` domain and debounces it with a four-state filter FSM. Produces a clean `level` plus one-cycle `rise`/`fall` strobes that the counter consumes instead of the raw pin. Also keeps a saturating count of rejected glitches for debug visibility.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal 2..4.
STABLE_CYCLES, 3, consecutive identical synchronised samples required to accept a new level; legal 2..(2^CNT_W - 1).
CNT_W, 4, width of the internal stability counter.
GLITCH_W, 8, width of `glitch_cnt`.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
in  input  1  raw asynchronous input; no timing relation to `clk`.
en  input  1  filter enable; 0 freezes the FSM.
glitch_clr  input  1  synchronous clear of `glitch_cnt`.
level  output  1  debounced level (registered).
rise  output  1  one-cycle strobe on accepted 0->1 (registered).
fall  output  1  one-cycle strobe on accepted 1->0 (registered).
glitch_cnt  output  GLITCH_W  saturating count of rejected transitions.
state  output  2  FSM state, for debug/monitor.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset (asynchronous, immediate):
  - all synchroniser flops = 0;
  - FSM = LOW, stability counter = 0;
  - `level` = 0, `rise` = 0, `fall` = 0, `glitch_cnt` = 0.
- Synchroniser:
  - SYNC_STAGES-deep flop chain on `in`; its last stage is `s`.
  - Runs regardless of `en`.
- FSM encoding: LOW = 0, CHK_H = 1, HIGH = 2, CHK_L = 3.
- LOW:
  - `s` = 1 -> CHK_H, cnt = 1.
  - Otherwise stay in LOW.
- CHK_H:
  - `s` = 1 and cnt + 1 == STABLE_CYCLES -> HIGH; `level` <= 1; `rise` <= 1 for that one cycle.
  - `s` = 1 otherwise -> cnt++.
  - `s` = 0 -> LOW, cnt = 0, `glitch_cnt`++.
- HIGH and CHK_L: mirror images of LOW and CHK_H with `s` inverted. Acceptance sets `level` <= 0 and `fall` <= 1; a rejection increments `glitch_cnt`.
- Latency: an `in` change that is stable across a clock edge is reflected in `level` (and its strobe) after exactly SYNC_STAGES + STABLE_CYCLES rising edges. With defaults that is the 5th edge.
- Strobes:
  - `rise`/`fall` are high for exactly one cycle per accepted edge.
  - They are never high simultaneously.
  - Both are 0 in every other cycle.
- `en` = 0:
  - FSM state, cnt and `level` hold; `rise`/`fall` forced 0.
  - `glitch_cnt` does not change except through `glitch_clr`.
  - The synchroniser keeps sampling.
  - When `en` returns to 1, the FSM resumes from the held state using the current `s`.
- `glitch_cnt`:
  - Saturates at 2^GLITCH_W - 1 (no wrap).
  - `glitch_clr` = 1 sets it to 0 on the next edge.
  - A clear and a glitch in the same cycle gives 0 (clear wins).
- Reset mid-operation (for example in CHK_H): all outputs drop to 0 immediately, without waiting for a clock. After `rst` is released, a high `in` again needs the full SYNC_STAGES + STABLE_CYCLES edges.
- `state` reflects the FSM register directly.

Test Plan:
1. Reset: `rst` = 1 for 2 cycles with `in` = 0, then release -> `level`/`rise`/`fall` = 0, `glitch_cnt` = 0, `state` = 0. Assert `rst` async between clock edges -> outputs 0 before the next edge.
2. Clean rise: defaults, clk period 10 ns; `in` 0->1 at t = 23 ns and held -> `rise` = 1 and `level` = 1 from the 5th rising edge after 23 ns. `rise` lasts exactly 1 cycle; `fall` stays 0; `glitch_cnt` = 0.
3. Short pulse: `in` high for 2 clock periods, then low -> `level` stays 0, no `rise`, `glitch_cnt` = 1, FSM returns to LOW.
4. Chatter: `in` toggles high 7 ns / low 12 ns for 300 ns with a 10 ns clock -> `level` never 1, `rise` never 1, `glitch_cnt` > 0. Pulse `glitch_clr` -> 0 next edge. Force 300 glitches with GLITCH_W = 8 -> saturates at 255.
5. Clean fall and reset mid-filter:
   - From HIGH, drop `in` and hold -> `fall` = 1 for 1 cycle at the 5th edge, `level` = 0.
   - Separately, assert `rst` while in CHK_H -> `state` = 0 immediately; after release, a 5-edge delay applies again.
6. Enable freeze: `en` = 0, raise `in` and hold for 10 cycles -> `level` = 0, `rise` = 0. Set `en` = 1 -> `level` = 1 and `rise` pulses after STABLE_CYCLES edges, since the synchroniser is already at 1.
